// File: rtl/framer_pkg.sv
// Shared framing constants and types for the sample framer and the FFT stage
// that consumes its frames.
package framer_pkg;

   localparam int FRAME_LEN = 16;
   localparam int SAMPLE_W  = 18;
   localparam int IDX_W     = $clog2(FRAME_LEN);

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_e;

   typedef logic [SAMPLE_W-1:0] sample_t;

   // Element 0 is the oldest sample of the frame.
   typedef sample_t [FRAME_LEN-1:0] frame_t;

endpackage

// File: rtl/sample_framer.sv
// Decimates a sample stream, collects 16-sample frames in a capture buffer and
// launches each complete frame to a held output register when the FFT is idle.
module sample_framer
   import framer_pkg::*;
#(
   parameter int unsigned DECIM = 1
)
(
   input  logic                clk,
   input  logic                reset,
   input  logic                sample_valid,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                fft_done,
   input  logic                clear_overrun,
   output logic [SAMPLE_W-1:0] t0,
   output logic [SAMPLE_W-1:0] t1,
   output logic [SAMPLE_W-1:0] t2,
   output logic [SAMPLE_W-1:0] t3,
   output logic [SAMPLE_W-1:0] t4,
   output logic [SAMPLE_W-1:0] t5,
   output logic [SAMPLE_W-1:0] t6,
   output logic [SAMPLE_W-1:0] t7,
   output logic [SAMPLE_W-1:0] t8,
   output logic [SAMPLE_W-1:0] t9,
   output logic [SAMPLE_W-1:0] t10,
   output logic [SAMPLE_W-1:0] t11,
   output logic [SAMPLE_W-1:0] t12,
   output logic [SAMPLE_W-1:0] t13,
   output logic [SAMPLE_W-1:0] t14,
   output logic [SAMPLE_W-1:0] t15,
   output logic                new_t,
   output logic                overrun,
   output logic [7:0]          drop_count,
   output logic [15:0]         frame_count
);

   localparam logic [7:0]       DECIM_M1 = 8'(DECIM - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
   logic [7:0]       dec_cnt_q, dec_cnt_d;
   frame_t           buf_q, buf_d;
   frame_t           t_q, t_d;
   logic             new_t_q, new_t_d;
   logic             overrun_q, overrun_d;
   logic [7:0]       drop_cnt_q, drop_cnt_d;
   logic [15:0]      frame_cnt_q, frame_cnt_d;

   logic eligible;
   logic launch;
   logic drop;

   // new_t_q doubles as the launch guard: no launch in the cycle after a launch.
   assign eligible = sample_valid && (dec_cnt_q == 8'd0);
   assign launch   = (state_q == FULL) && fft_done && !new_t_q;
   assign drop     = (state_q == FULL) && !launch && eligible;

   // NOTE: every variable gets its hold value first so no path leaves it
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      state_d     = state_q;
      wr_idx_d    = wr_idx_q;
      dec_cnt_d   = dec_cnt_q;
      buf_d       = buf_q;
      t_d         = t_q;
      new_t_d     = 1'b0;
      overrun_d   = overrun_q;
      drop_cnt_d  = drop_cnt_q;
      frame_cnt_d = frame_cnt_q;

      if (sample_valid) begin
         dec_cnt_d = (dec_cnt_q == DECIM_M1) ? 8'd0 : dec_cnt_q + 8'd1;
      end

      case (state_q)
         FILL: begin
            if (eligible) begin
               buf_d[wr_idx_q] = sample_in;
               wr_idx_d        = wr_idx_q + 1'b1;
               if (wr_idx_q == LAST_IDX) begin
                  state_d = FULL;
               end
            end
         end
         FULL: begin
            if (launch) begin
               t_d         = buf_q;
               new_t_d     = 1'b1;
               frame_cnt_d = frame_cnt_q + 16'd1;
               state_d     = FILL;
               // A sample arriving with the launch opens the next frame.
               if (eligible) begin
                  buf_d[0] = sample_in;
                  wr_idx_d = IDX_W'(1);
               end
            end
         end
         default: state_d = FILL;
      endcase

      if (clear_overrun) begin
         overrun_d  = 1'b0;
         drop_cnt_d = drop ? 8'd1 : 8'd0;
      end else if (drop) begin
         overrun_d = 1'b1;
         if (drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= FILL;
         wr_idx_q    <= '0;
         dec_cnt_q   <= '0;
         t_q         <= '0;
         new_t_q     <= 1'b0;
         overrun_q   <= 1'b0;
         drop_cnt_q  <= '0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wr_idx_q    <= wr_idx_d;
         dec_cnt_q   <= dec_cnt_d;
         t_q         <= t_d;
         new_t_q     <= new_t_d;
         overrun_q   <= overrun_d;
         drop_cnt_q  <= drop_cnt_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // NOTE: the capture buffer is deliberately not reset; a frame is only
   // launched after all 16 entries have been rewritten since reset.
   always_ff @(posedge clk) begin
      buf_q <= buf_d;
   end

   assign t0          = t_q[0];
   assign t1          = t_q[1];
   assign t2          = t_q[2];
   assign t3          = t_q[3];
   assign t4          = t_q[4];
   assign t5          = t_q[5];
   assign t6          = t_q[6];
   assign t7          = t_q[7];
   assign t8          = t_q[8];
   assign t9          = t_q[9];
   assign t10         = t_q[10];
   assign t11         = t_q[11];
   assign t12         = t_q[12];
   assign t13         = t_q[13];
   assign t14         = t_q[14];
   assign t15         = t_q[15];
   assign new_t       = new_t_q;
   assign overrun     = overrun_q;
   assign drop_count  = drop_cnt_q;
   assign frame_count = frame_cnt_q;

endmodule

// File: doc/sample_framer.md
SAMPLE_FRAMER -- requirements
Module: sample_framer

Interface
REQ-001 Parameter DECIM, default 1, keeps every DECIM-th valid sample (legal range 1..255).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 sample_valid  input  1  one-cycle strobe qualifying sample_in.
REQ-005 sample_in  input  18  signed two's-complement audio sample.
REQ-006 fft_done  input  1  high when the downstream FFT is idle and may take a frame.
REQ-007 clear_overrun  input  1  synchronous clear of overrun.
REQ-008 t0..t15  output  18 each  held frame to the FFT; t0 is the oldest sample, t15 the newest.
REQ-009 new_t  output  1  one-cycle launch pulse; t0..t15 hold the new frame in the same cycle.
REQ-010 overrun  output  1  sticky flag; a sample was dropped.
REQ-011 drop_count  output  8  count of dropped samples; saturates at 255.
REQ-012 frame_count  output  16  frames launched; wraps from 65535 to 0.

Function
REQ-013 Valid-sample qualification: decimation counter counts 0..DECIM-1 on each sample_valid; a sample is eligible only when the counter equals 0; DECIM=1 makes every valid sample eligible.
REQ-014 Capture buffer: 16 x 18 bits, separate from t0..t15 (double buffer); write index wr_idx is 4 bits.
REQ-015 FSM states: FILL, FULL.
REQ-016 FILL, eligible sample: write buf[wr_idx], then increment wr_idx.
REQ-017 FILL: on the edge that writes wr_idx=15, the next state is FULL and wr_idx wraps to 0.
REQ-018 FULL with fft_done=1 and no launch on the previous cycle:
  - t0..t15 <= buf[0..15];
  - new_t <= 1;
  - frame_count increments;
  - next state is FILL.
  new_t therefore goes high two cycles after the 16th sample is accepted.
REQ-019 Launch-cycle sample: an eligible sample arriving in the launch cycle of REQ-018 is written to buf[0] of the next frame, and wr_idx becomes 1.
REQ-020 Launch guard: fft_done is ignored in the cycle after new_t; new_t is never high on two consecutive cycles.
REQ-021 FULL with fft_done=0: an eligible sample is dropped, overrun <= 1, and drop_count increments (saturating); buf and wr_idx are unchanged.
REQ-022 new_t is registered and high for exactly one cycle; t0..t15 change only on a launch edge and hold between launches.
REQ-023 Samples are passed unmodified (full 18 bits); bit selection and scaling belong to the FFT stage.
REQ-024 clear_overrun=1 clears overrun and drop_count to 0. If a drop occurs in the same cycle, the clear wins for overrun, and drop_count is set to 1.
REQ-025 The decimation counter runs in every state, including FULL; dropped samples still advance it.

Reset
REQ-026 With reset=0 at a clock edge, all of the following go to 0, and the FSM goes to FILL:
  - t0..t15, new_t, overrun, drop_count, frame_count;
  - wr_idx and the decimation counter;
  - the launch guard.
REQ-027 Reset mid-frame discards the partial frame, and no new_t is issued for it.
REQ-028 Buffer contents need not be cleared, but they are never launched before being rewritten with 16 new samples.

Structure
REQ-029 Shared package framer_pkg holds:
  - FRAME_LEN=16;
  - SAMPLE_W=18;
  - the FSM state enum {FILL, FULL};
  - the frame array typedef (16 x SAMPLE_W).
  The FFT stage reuses FRAME_LEN and SAMPLE_W from this package.
REQ-030 Single module; no sub-module is required, and the FSM, counters and buffers are written inline.

Verification
REQ-031 DECIM=1, fft_done=1, samples 1..16 on consecutive cycles:
  - new_t pulses once, 2 cycles after sample 16;
  - t0=1 and t15=16;
  - frame_count=1.
REQ-032 Continuous samples 1..32, fft_done=1:
  - two new_t pulses 16 cycles apart;
  - second frame t0=17, t15=32;
  - overrun=0.
REQ-033 fft_done=0 after the frame is full, 5 more samples, then fft_done=1:
  - overrun=1 and drop_count=5;
  - launched frame is 1..16;
  - the next frame starts with the first sample after the launch.
REQ-034 DECIM=4, samples 0..63: frame is t0=0, t1=4, ..., t15=60.
REQ-035 Reset asserted after 10 samples, then samples 100..115:
  - no launch for the partial frame;
  - t0=100 and t15=115;
  - frame_count=1.
REQ-036 Drop and clear_overrun=1 in the same cycle: overrun=0 and drop_count=1.
